intc27_ack_seq: RTL

- Sequential front/back end wrapped around the 27-channel combinational priority stage.
- Synchronizes and edge-latches 27 raw request lines (groups A/B/C, 9 channels each) into pending registers that drive the priority stage's A/B/C inputs.
- Captures the stage's winner (group flags plus channel index) and raises a CPU interrupt. On CPU acknowledge, it clears exactly the serviced pending bit.

---
 rtl/intc27_ack_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/intc27_ack_seq.sv
// Interrupt front/back end around the 27-channel priority stage.
// Optional ASSERT timeout abort: define INTC_ACK_TIMEOUT_EN.
module intc27_ack_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] req_a,
  input  logic [8:0] req_b,
  input  logic [8:0] req_c,
  input  logic [8:0] en,
  output logic [8:0] pend_a,
  output logic [8:0] pend_b,
  output logic [8:0] pend_c,
  input  logic       pa,
  input  logic       pb,
  input  logic       pc,
  input  logic [3:0] chan,
  output logic       irq,
  output logic [5:0] vec,
  input  logic       ack,
  output logic       busy
`ifdef INTC_ACK_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARB    = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

`ifdef INTC_ACK_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
`endif

  logic [26:0] r_sync [SYNC_STAGES];
  logic [26:0] r_hist;
  logic [26:0] r_pend;
  logic [1:0]  r_state;
  logic [1:0]  r_grp;
  logic [3:0]  r_chan;
  logic        r_irq;

  logic [26:0] w_raw;
  logic [26:0] w_sync;
  logic [26:0] w_rise;
  logic [26:0] w_clr;
  logic [4:0]  w_base;
  logic [4:0]  w_idx;
  logic [1:0]  w_grp;
  logic        w_any;
  logic        w_win;

`ifdef INTC_ACK_TIMEOUT_EN
  logic [15:0] r_tcnt;
  logic        r_to;
`endif

  assign w_raw  = {req_c, req_b, req_a};
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_hist <= w_sync;
    end
  end

  always_comb begin
    w_base = 5'd0;
    case (r_grp)
      2'd2:    w_base = 5'd9;
      2'd3:    w_base = 5'd18;
      default: w_base = 5'd0;
    endcase
  end

  assign w_idx = w_base + {1'b0, r_chan};

  // Out-of-range channel index clears nothing
  assign w_clr = (r_state == ST_CLEAR &&
                  r_grp != 2'd0 &&
                  r_chan <= 4'd8) ?
                 (27'd1 << w_idx) : '0;

  // New edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pend <= '0;
    else
      r_pend <= (r_pend & ~w_clr) | w_rise;
  end

  assign w_any = |((pend_a | pend_b | pend_c) & en);
  assign w_win = pa | pb | pc;

  always_comb begin
    w_grp = 2'd0;
    if (pa)
      w_grp = 2'd1;
    else if (pb)
      w_grp = 2'd2;
    else if (pc)
      w_grp = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grp   <= 2'd0;
      r_chan  <= 4'd0;
      r_irq   <= 1'b0;
`ifdef INTC_ACK_TIMEOUT_EN
      r_tcnt  <= 16'd0;
      r_to    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any)
            r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (w_win) begin
            r_state <= ST_ASSERT;
            r_grp   <= w_grp;
            r_chan  <= chan;
            r_irq   <= 1'b1;
`ifdef INTC_ACK_TIMEOUT_EN
            r_tcnt  <= 16'd0;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ASSERT: begin
          if (ack) begin
            r_state <= ST_CLEAR;
            r_irq   <= 1'b0;
          end
`ifdef INTC_ACK_TIMEOUT_EN
          else if (r_tcnt == TO_LAST) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_grp   <= 2'd0;
            r_chan  <= 4'd0;
            r_to    <= 1'b1;
          end else begin
            r_tcnt  <= r_tcnt + 16'd1;
          end
`endif
        end
        ST_CLEAR: begin
          r_state <= ST_IDLE;
          r_grp   <= 2'd0;
          r_chan  <= 4'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pend_a = r_pend[8:0];
  assign pend_b = r_pend[17:9];
  assign pend_c = r_pend[26:18];
  assign irq    = r_irq;
  assign vec    = {r_grp, r_chan};
  assign busy   = (r_state != ST_IDLE);
`ifdef INTC_ACK_TIMEOUT_EN
  assign timeout = r_to;
`endif

endmodule
